// File: rtl/vk_reset_seq.sv
// vk_reset_seq: reset sequencer in the clk_i domain (after the reset synchroniser).
// Turns the system reset plus soft/watchdog reset requests into N_STAGES ordered
// stage resets: every stage is held for ASSERT_CYC cycles once the reset cause ends,
// then stages are released one at a time, GAP_CYC cycles apart, bit 0 first.
//
// Ports:
//   clk_i     in   system clock
//   areset_i  in   asynchronous reset, active-high (deassertion synchronous to clk_i)
//   sw_req_i  in   software reset request, level
//   wd_req_i  in   watchdog reset request, level
//   rst_o     out  [N_STAGES-1:0] stage resets, active-high, bit 0 released first
//   done_o    out  all stages released
//   busy_o    out  sequence in progress (always ~done_o)
//   cause_o   out  [1:0] last request cause {wd,sw}; 00 = areset/power-on only
module vk_reset_seq #(
  parameter int N_STAGES   = 3,
  parameter int ASSERT_CYC = 16,
  parameter int GAP_CYC    = 8
) (
  input  logic                clk_i,
  input  logic                areset_i,
  input  logic                sw_req_i,
  input  logic                wd_req_i,
  output logic [N_STAGES-1:0] rst_o,
  output logic                done_o,
  output logic                busy_o,
  output logic [1:0]          cause_o
);

  localparam int MAX_CYC = (ASSERT_CYC > GAP_CYC) ? ASSERT_CYC : GAP_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int SW      = $clog2(N_STAGES + 1);

  localparam logic [CW-1:0]       ASSERT_LAST = CW'(ASSERT_CYC - 1);
  localparam logic [CW-1:0]       GAP_LAST    = CW'(GAP_CYC - 1);
  localparam logic [SW-1:0]       STAGE_LAST  = SW'(N_STAGES - 1);
  localparam logic [N_STAGES-1:0] STAGE_ONE   = N_STAGES'(1);

  typedef enum logic [1:0] {
    S_ASSERT,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] stage;

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      state   <= S_ASSERT;
      cnt     <= '0;
      stage   <= '0;
      rst_o   <= '1;
      done_o  <= 1'b0;
      busy_o  <= 1'b1;
      cause_o <= '0;
    end else if (sw_req_i || wd_req_i) begin
      // A held request keeps cnt at 0; counting resumes on the first request-free edge.
      state   <= S_ASSERT;
      cnt     <= '0;
      stage   <= '0;
      rst_o   <= '1;
      done_o  <= 1'b0;
      busy_o  <= 1'b1;
      cause_o <= {wd_req_i, sw_req_i};
    end else begin
      case (state)
        S_ASSERT: begin
          if (cnt == ASSERT_LAST) begin
            rst_o <= rst_o & ~STAGE_ONE;
            cnt   <= '0;
            stage <= SW'(1);
            if (N_STAGES == 1) begin
              state  <= S_DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state <= S_RELEASE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RELEASE: begin
          if (cnt == GAP_LAST) begin
            rst_o <= rst_o & ~(STAGE_ONE << stage);
            cnt   <= '0;
            stage <= stage + SW'(1);
            if (stage == STAGE_LAST) begin
              state  <= S_DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          rst_o  <= '0;
          done_o <= 1'b1;
          busy_o <= 1'b0;
        end
        default: begin
          state <= S_ASSERT;
          cnt   <= '0;
          stage <= '0;
          rst_o <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vk_reset_seq.sv
// Testbench for vk_reset_seq: default-parameter instance checked every cycle against
// a model that derives outputs from the number of request-free edges since the last
// reset cause, plus literal checks of the documented release timeline; a second
// instance with N_STAGES=1, ASSERT_CYC=GAP_CYC=1 is checked for release on edge 1.
module tb_vk_reset_seq;

  localparam int N = 3;
  localparam int A = 16;
  localparam int G = 8;

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic         sw_req = 1'b0;
  logic         wd_req = 1'b0;
  logic [N-1:0] rst;
  logic         done, busy;
  logic [1:0]   cause;
  logic [0:0]   rst1;
  logic         done1, busy1;
  logic [1:0]   cause1;

  int pass_cnt = 0;
  int total_cnt = 0;

  vk_reset_seq #(.N_STAGES(N), .ASSERT_CYC(A), .GAP_CYC(G)) dut (
    .clk_i(clk), .areset_i(areset), .sw_req_i(sw_req), .wd_req_i(wd_req),
    .rst_o(rst), .done_o(done), .busy_o(busy), .cause_o(cause)
  );

  vk_reset_seq #(.N_STAGES(1), .ASSERT_CYC(1), .GAP_CYC(1)) dut1 (
    .clk_i(clk), .areset_i(areset), .sw_req_i(sw_req), .wd_req_i(wd_req),
    .rst_o(rst1), .done_o(done1), .busy_o(busy1), .cause_o(cause1)
  );

  always #5 clk = ~clk;

  // Model: n = request-free edges since the last reset cause (saturating).
  // Stage k is released once n reaches A + k*G.
  int       m_n = 0;
  logic [1:0] m_cause = 2'b00;

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      m_n     <= 0;
      m_cause <= 2'b00;
    end else if (sw_req || wd_req) begin
      m_n     <= 0;
      m_cause <= {wd_req, sw_req};
    end else if (m_n < 1000) begin
      m_n <= m_n + 1;
    end
  end

  function automatic logic [N-1:0] model_rst(int n);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = (n < A + k * G);
    return r;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  // Cycle compare against the model on every falling edge.
  always @(negedge clk) begin
    check("cyc_rst", 32'(rst), 32'(model_rst(m_n)));
    check("cyc_done", 32'(done), 32'(m_n >= A + (N - 1) * G));
    check("cyc_busy", 32'(busy), 32'(!(m_n >= A + (N - 1) * G)));
    check("cyc_cause", 32'(cause), 32'(m_cause));
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_state_rst", 32'(rst), 32'b111);
    check("rst_state_done", 32'(done), 0);
    check("rst_state_busy", 32'(busy), 1);
    check("rst_state_cause", 32'(cause), 0);
    check("n1_rst_in_reset", 32'(rst1), 1);

    // Test 1 + 6: release areset; next edge is edge 1
    areset = 1'b0;
    tick(1);
    check("n1_rst_edge1", 32'(rst1), 0);
    check("n1_done_edge1", 32'(done1), 1);
    tick(14);
    check("t1_e15", 32'(rst), 32'b111);
    tick(1);
    check("t1_e16", 32'(rst), 32'b110);
    tick(7);
    check("t1_e23", 32'(rst), 32'b110);
    tick(1);
    check("t1_e24", 32'(rst), 32'b100);
    tick(7);
    check("t1_e31_done", 32'(done), 0);
    tick(1);
    check("t1_e32", 32'(rst), 32'b000);
    check("t1_e32_done", 32'(done), 1);
    check("t1_cause", 32'(cause), 0);
    tick(3);

    // Test 2: one-cycle sw pulse from S_DONE
    sw_req = 1'b1;
    tick(1);
    check("t2_req_rst", 32'(rst), 32'b111);
    check("t2_cause", 32'(cause), 2'b01);
    sw_req = 1'b0;
    tick(15);
    check("t2_e15", 32'(rst), 32'b111);
    tick(1);
    check("t2_e16", 32'(rst), 32'b110);

    // Test 3: wd held 10 cycles while rst_o=110
    tick(2);
    wd_req = 1'b1;
    tick(1);
    check("t3_req_rst", 32'(rst), 32'b111);
    check("t3_cause", 32'(cause), 2'b10);
    tick(9);
    check("t3_held_rst", 32'(rst), 32'b111);
    wd_req = 1'b0;
    tick(15);
    check("t3_e15", 32'(rst), 32'b111);
    tick(1);
    check("t3_e16", 32'(rst), 32'b110);
    check("t3_cause_kept", 32'(cause), 2'b10);

    // Test 4: both requests, then asynchronous areset pulse
    sw_req = 1'b1;
    wd_req = 1'b1;
    tick(1);
    check("t4_cause11", 32'(cause), 2'b11);
    sw_req = 1'b0;
    wd_req = 1'b0;
    tick(17);
    check("t4_e16", 32'(rst), 32'b110);
    areset = 1'b1;
    #1;
    check("t4_async_rst", 32'(rst), 32'b111);
    check("t4_async_cause", 32'(cause), 0);
    check("t4_async_done", 32'(done), 0);
    #2;
    areset = 1'b0;

    // Test 5: areset pulse at edge 20, then full restart
    tick(20);
    check("t5_e20", 32'(rst), 32'b110);
    areset = 1'b1;
    #1;
    check("t5_async_rst", 32'(rst), 32'b111);
    #2;
    areset = 1'b0;
    tick(15);
    check("t5_e15", 32'(rst), 32'b111);
    tick(1);
    check("t5_e16", 32'(rst), 32'b110);
    tick(8);
    check("t5_e24", 32'(rst), 32'b100);
    tick(8);
    check("t5_e32", 32'(rst), 32'b000);
    check("t5_done", 32'(done), 1);
    tick(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
